// File: rtl/seq_decoder.sv
// seq_decoder: registered N-to-2^N one-hot decoder with enable and a dwell-timed scan mode.
module seq_decoder #(
  parameter int N = 2,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           En,
  input  logic           mode,
  input  logic [N-1:0]   w,
  output logic [0:2**N-1] y,
  output logic [N-1:0]   code,
  output logic           wrap
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [1:0] IDLE = 2'd0, DIRECT = 2'd1, SCAN = 2'd2;
  logic [1:0] state, nxt;
  logic [DW-1:0] dwell;
  logic [N-1:0] code_inc;
  function automatic logic [0:2**N-1] onehot(input logic [N-1:0] c);
    onehot = '0;
    onehot[c] = 1'b1;
  endfunction
  always_comb begin
    nxt = !En ? IDLE : mode ? SCAN : DIRECT;
    code_inc = code + 1'b1;
  end
  // Scan entry is detected from the previous state, so a mode or enable change restarts at w.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      code <= '0;
      y <= '0;
      wrap <= 1'b0;
      dwell <= '0;
    end else begin
      state <= nxt;
      wrap <= 1'b0;
      dwell <= '0;
      if (nxt == IDLE)
        y <= '0;
      else if (nxt == DIRECT || state != SCAN) begin
        code <= w;
        y <= onehot(w);
      end else if (dwell == DW'(DIV - 1)) begin
        code <= code_inc;
        y <= onehot(code_inc);
        wrap <= &code;
      end else
        dwell <= dwell + 1'b1;
    end
endmodule
